axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
AXI4 slave memory that answers the CPU's AXI master port (4-bit ID, 32-bit address/data, FIXED/INCR/WRAP bursts up to 256 beats). It replaces the vendor AXI block-memory IP in simulation and small builds. Independent read and write engines share one byte-writable word array, with one outstanding transaction per direction.

Parameters:
MEM_WORDS_LOG2  12  array depth = 2**MEM_WORDS_LOG2 32-bit words
BASE_ADDR  32'h0000_0000  byte address of word 0; aligned to array size

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_awid  in  4  write ID
s_axi_awaddr  in  32  write start byte address
s_axi_awlen  in  8  beats-1
s_axi_awburst  in  2  write burst type
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wlast  in  1  final write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  4  response ID
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  4  read ID
s_axi_araddr  in  32  read start byte address
s_axi_arlen  in  8  beats-1
s_axi_arburst  in  2  read burst type
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  4  read ID echo
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  per-beat read response
s_axi_rlast  out  1  final read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset: read FSM goes to R_IDLE and write FSM to W_IDLE. arready=1, awready=1; wready, rvalid, rlast, bvalid=0; rdata, rid, rresp, bid, bresp=0. Array is not cleared. Reset mid-burst abandons the burst with no response.
- Beats are always 4 bytes (no size ports). Address bits [1:0] are ignored for indexing. Responses: OKAY 00, SLVERR 10, DECERR 11. Per-beat priority: DECERR > SLVERR > OKAY.
- FIXED: same address every beat. INCR: +4 per beat. WRAP: +4, wrapping inside an aligned window of (len+1)*4 bytes; len must be 1, 3, 7 or 15, otherwise the burst runs as INCR with SLVERR on every beat. Burst 2'b11 runs as INCR with SLVERR.
- Decode: any beat address outside [BASE_ADDR, BASE_ADDR+4*2**MEM_WORDS_LOG2) gets DECERR; read data is 0 and the write is dropped. Checked per beat.
- Read FSM R_IDLE→R_DATA on AR handshake; arready=1 only in R_IDLE. Beat 0 rvalid appears the cycle after AR handshake (registered read). Each R handshake loads the next beat at that edge, so rready held high gives one beat per cycle. rid = captured arid; rlast only on beat len. All R outputs are held stable while rvalid & !rready. After the last handshake, return to R_IDLE (arready=1 next cycle).
- Write FSM W_IDLE→W_DATA on AW handshake; awready=1 only in W_IDLE. wready=1 only in W_DATA, so W before AW waits. Each W handshake writes byte i (wdata[8i+7:8i]) where wstrb[i]=1, at that edge.
- Beat counter, not wlast, ends the burst. wlast=1 on a non-final beat or wlast=0 on the final beat sets a sticky SLVERR.
- After the final beat, go to W_RESP: bvalid=1, bid=awid, bresp = worst response of the burst, held until bready; then W_IDLE.
- Same word read-issued and written in the same cycle: the read returns old data.

Test Plan:
1. Write 0..3 to 0x100; then AR 0x100 len 3 INCR id 5 with rready=1 -> rdata 0,1,2,3 on consecutive cycles starting at T+1, rlast on beat 4, rid=5, rresp=00.
2. AW 0x110 len 15 id 2, W 0x0..0xF strb F, bready low 3 cycles -> bvalid held, bid=2, bresp=00; readback matches. Strb 0101 data 0xAABBCCDD over 0x11223344 -> 0x11BB33DD.
3. WRAP AR 0x38 len 3 -> beat addresses 0x38, 0x3C, 0x30, 0x34. WRAP len 2 -> INCR addresses, rresp=10 on all beats.
4. rready pattern 1,0,0,1,... during a len 7 read -> each beat held stable, no loss or duplicate. wlast on beat 2 of len 3 -> all 4 beats written, bresp=10.
5. AR at BASE+4*2**N-4 len 1 -> beat0 OKAY, beat1 DECERR with data 0. rst mid write burst -> next cycle awready=1, wready=0, bvalid=0.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a byte-writable word array.
// Independent read/write engines, one outstanding burst per direction, 4-byte beats.
module axi_sram_slave #(
    parameter int          MEM_WORDS_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  s_axi_awid,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [3:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [3:0]  s_axi_arid,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [3:0]  s_axi_rid,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);
    localparam int IW = MEM_WORDS_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] M_FIXED = 2'd0;
    localparam logic [1:0] M_INCR  = 2'd1;
    localparam logic [1:0] M_WRAP  = 2'd2;

    logic [31:0] mem [0:(1<<IW)-1];

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) || (burst == 2'b10 && !wrap_len_ok(len));
    endfunction

    // Illegal WRAP lengths and the reserved encoding degrade to INCR.
    function automatic logic [1:0] eff_mode(input logic [1:0] burst, input logic [7:0] len);
        case (burst)
            2'b00:   return M_FIXED;
            2'b10:   return wrap_len_ok(len) ? M_WRAP : M_INCR;
            default: return M_INCR;
        endcase
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] mode,
                                              input logic [7:0] len);
        logic [31:0] mask;
        mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
        case (mode)
            M_FIXED: return a;
            M_WRAP:  return (a & ~mask) | ((a + 32'd4) & mask);
            default: return a + 32'd4;
        endcase
    endfunction

    // BASE_ADDR is aligned to the array size, so decode is an upper-bit compare.
    function automatic logic in_range(input logic [31:0] a);
        return a[31:IW+2] == BASE_ADDR[31:IW+2];
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        return a[IW+1:2];
    endfunction

    function automatic logic [1:0] beat_resp(input logic hit, input logic err);
        return !hit ? RESP_DECERR : (err ? RESP_SLVERR : RESP_OKAY);
    endfunction

    // ---------------- read engine ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_beat;
    logic [1:0]  r_mode;
    logic        r_err;
    logic [31:0] r_next;

    assign r_next = next_addr(r_addr, r_mode, r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rid     <= '0;
            s_axi_rresp   <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_beat        <= '0;
            r_mode        <= M_INCR;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (s_axi_arvalid && s_axi_arready) begin
                    s_axi_arready <= 1'b0;
                    s_axi_rvalid  <= 1'b1;
                    s_axi_rid     <= s_axi_arid;
                    s_axi_rlast   <= (s_axi_arlen == 8'd0);
                    s_axi_rdata   <= in_range(s_axi_araddr) ? mem[word_idx(s_axi_araddr)] : 32'd0;
                    s_axi_rresp   <= beat_resp(in_range(s_axi_araddr),
                                               burst_err(s_axi_arburst, s_axi_arlen));
                    r_addr        <= s_axi_araddr;
                    r_len         <= s_axi_arlen;
                    r_beat        <= 8'd0;
                    r_mode        <= eff_mode(s_axi_arburst, s_axi_arlen);
                    r_err         <= burst_err(s_axi_arburst, s_axi_arlen);
                    r_state       <= R_DATA;
                end
                R_DATA: if (s_axi_rready) begin
                    if (s_axi_rlast) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_rlast   <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end else begin
                        r_addr      <= r_next;
                        r_beat      <= r_beat + 8'd1;
                        s_axi_rlast <= (r_beat + 8'd1 == r_len);
                        s_axi_rdata <= in_range(r_next) ? mem[word_idx(r_next)] : 32'd0;
                        s_axi_rresp <= beat_resp(in_range(r_next), r_err);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write engine ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [7:0]  w_beat;
    logic [1:0]  w_mode;
    logic        w_err;
    logic [1:0]  w_worst;
    logic        w_fire;
    logic        w_final;
    logic        w_hit;
    logic [1:0]  w_resp_beat;
    logic [1:0]  w_worst_nxt;

    assign w_fire      = s_axi_wvalid && s_axi_wready;
    assign w_final     = (w_beat == w_len);
    assign w_hit       = in_range(w_addr);
    // The beat counter ends the burst; a misplaced wlast only flags the response.
    assign w_resp_beat = beat_resp(w_hit, w_err || (s_axi_wlast != w_final));
    assign w_worst_nxt = (w_resp_beat > w_worst) ? w_resp_beat : w_worst;

    always_ff @(posedge clk) begin
        if (w_fire && w_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (s_axi_wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_beat        <= '0;
            w_mode        <= M_INCR;
            w_err         <= 1'b0;
            w_worst       <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: if (s_axi_awvalid && s_axi_awready) begin
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b1;
                    s_axi_bid     <= s_axi_awid;
                    w_addr        <= s_axi_awaddr;
                    w_len         <= s_axi_awlen;
                    w_beat        <= 8'd0;
                    w_mode        <= eff_mode(s_axi_awburst, s_axi_awlen);
                    w_err         <= burst_err(s_axi_awburst, s_axi_awlen);
                    w_worst       <= RESP_OKAY;
                    w_state       <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    if (w_final) begin
                        s_axi_wready <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= w_worst_nxt;
                        w_state      <= W_RESP;
                    end else begin
                        w_addr  <= next_addr(w_addr, w_mode, w_len);
                        w_beat  <= w_beat + 8'd1;
                        w_worst <= w_worst_nxt;
                    end
                end
                W_RESP: if (s_axi_bready) begin
                    s_axi_bvalid  <= 1'b0;
                    s_axi_awready <= 1'b1;
                    w_state       <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: table of read bursts over a preloaded
// pattern, plus hand sequences for strobes, stalls, errors and reset.
module tb_axi_sram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    axi_sram_slave #(.MEM_WORDS_LOG2(12), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    logic [31:0] wbuf [256];
    logic [31:0] edat [256];
    logic [1:0]  eres [256];

    typedef struct {
        logic [31:0]      addr;
        int               len;
        logic [1:0]       burst;
        logic [3:0]       id;
        logic [3:0][31:0] ea;
        logic [1:0]       resp;
    } rvec_t;

    rvec_t tbl [6];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    function automatic rvec_t mk(input logic [31:0] addr, input int len, input logic [1:0] burst,
                                 input logic [3:0] id, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [31:0] a3, input logic [1:0] resp);
        rvec_t v;
        v.addr = addr; v.len = len; v.burst = burst; v.id = id;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
        v.resp = resp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, output bit ok);
        awaddr = a; awlen = len; awburst = burst; awid = id; awvalid = 1'b1; ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; tick(); break; end
            tick();
        end
        awvalid = 1'b0;
        if (!ok) chk("aw_timeout", 0, 1);
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1; ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wready) begin ok = 1; tick(); break; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (!ok) chk("w_timeout", 0, 1);
    endtask

    // bad: beat index whose wlast is inverted (-1 for none)
    task automatic do_write(input logic [31:0] a, input int len, input logic [1:0] burst,
                            input logic [3:0] id, input logic [3:0] s, input int bad,
                            input int bdelay, input logic [1:0] exp_resp, input string name);
        bit ok;
        aw_send(a, len[7:0], burst, id, ok);
        if (!ok) return;
        for (int b = 0; b <= len; b++) begin
            w_send(wbuf[b], s, (b == len) != (b == bad), ok);
            if (!ok) return;
        end
        for (int d = 0; d < bdelay; d++) begin
            @(negedge clk);
            chk({name, " bvalid_held"}, {31'd0, bvalid}, 32'd1);
            tick();
        end
        bready = 1'b1; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid) begin
                ok = 1;
                chk({name, " bid"}, {28'd0, bid}, {28'd0, id});
                chk({name, " bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
                tick();
                break;
            end
            tick();
        end
        bready = 1'b0;
        if (!ok) chk({name, " b_timeout"}, 0, 1);
    endtask

    // rmode 0: rready always high; rmode 1: rready pattern 1,0,0 repeating
    task automatic do_read(input logic [31:0] a, input int len, input logic [1:0] burst,
                           input logic [3:0] id, input int rmode, input string name);
        bit ok;
        int hs_cyc, last_cyc, beat;
        araddr = a; arlen = len[7:0]; arburst = burst; arid = id; arvalid = 1'b1; ok = 0;
        hs_cyc = 0; last_cyc = 0; beat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; hs_cyc = cyc; tick(); break; end
            tick();
        end
        arvalid = 1'b0;
        if (!ok) begin chk({name, " ar_timeout"}, 0, 1); return; end
        for (int i = 0; i < 4 * (len + 1) + 10 && beat <= len; i++) begin
            rready = (rmode == 0) ? 1'b1 : (i % 3 == 0);
            @(negedge clk);
            if (i == 0) chk({name, " first_beat_latency"}, {31'd0, rvalid}, 32'd1);
            if (rvalid) begin
                chk({name, " rdata"}, rdata, edat[beat]);
                chk({name, " rid/rresp/rlast"}, {25'd0, rid, rresp, rlast},
                    {25'd0, id, eres[beat], beat == len});
                if (rready) begin last_cyc = cyc; beat++; end
            end
            tick();
        end
        rready = 1'b0;
        if (beat <= len) chk({name, " r_timeout"}, beat, len + 1);
        if (rmode == 0) chk({name, " back_to_back"}, last_cyc - hs_cyc, len + 1);
        @(negedge clk);
        chk({name, " arready_after"}, {31'd0, arready}, 32'd1);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst = 1'b1;
        awid = 0; awaddr = 0; awlen = 0; awburst = 2'b01; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arburst = 2'b01; arvalid = 0; rready = 0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset ready/valid", {26'd0, arready, awready, wready, rvalid, rlast, bvalid},
            {26'd0, 6'b110000});
        chk("reset rdata", rdata, 32'd0);
        chk("reset ids/resps", {20'd0, rid, rresp, bid, bresp}, 32'd0);
        tick();

        // W presented before AW must stall
        wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        repeat (2) begin @(negedge clk); chk("w_before_aw wready", {31'd0, wready}, 32'd0); tick(); end
        wvalid = 1'b0;

        // preload 0x000..0x0FC with pat(addr)
        for (int i = 0; i < 64; i++) wbuf[i] = pat(32'(4 * i));
        do_write(32'h0, 63, 2'b01, 4'd3, 4'hF, -1, 0, 2'b00, "preload");

        // write 0..3 at 0x100, read back back-to-back
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i); edat[i] = 32'(i); eres[i] = 2'b00; end
        do_write(32'h100, 3, 2'b01, 4'd1, 4'hF, -1, 0, 2'b00, "wr0x100");
        do_read(32'h100, 3, 2'b01, 4'd5, 0, "rd0x100");

        tbl[0] = mk(32'h38, 3, 2'b10, 4'd1, 32'h38, 32'h3C, 32'h30, 32'h34, 2'b00);
        tbl[1] = mk(32'h38, 2, 2'b10, 4'd2, 32'h38, 32'h3C, 32'h40, 32'h0, 2'b10);
        tbl[2] = mk(32'h20, 2, 2'b00, 4'd3, 32'h20, 32'h20, 32'h20, 32'h0, 2'b00);
        tbl[3] = mk(32'h10, 1, 2'b11, 4'd4, 32'h10, 32'h14, 32'h0,  32'h0, 2'b10);
        tbl[4] = mk(32'h0C, 1, 2'b10, 4'd5, 32'h0C, 32'h08, 32'h0,  32'h0, 2'b00);
        tbl[5] = mk(32'h44, 0, 2'b01, 4'd6, 32'h44, 32'h0,  32'h0,  32'h0, 2'b00);
        for (int t = 0; t < 6; t++) begin
            for (int b = 0; b <= tbl[t].len; b++) begin
                edat[b] = pat(tbl[t].ea[b]);
                eres[b] = tbl[t].resp;
            end
            do_read(tbl[t].addr, tbl[t].len, tbl[t].burst, tbl[t].id, 0, $sformatf("table%0d", t));
        end

        // 16-beat write with delayed bready
        for (int i = 0; i < 16; i++) begin wbuf[i] = 32'(i); edat[i] = 32'(i); eres[i] = 2'b00; end
        do_write(32'h110, 15, 2'b01, 4'd2, 4'hF, -1, 3, 2'b00, "wr16");
        do_read(32'h110, 15, 2'b01, 4'd2, 0, "rd16");

        // partial strobes
        wbuf[0] = 32'h1122_3344;
        do_write(32'h200, 0, 2'b01, 4'd4, 4'hF, -1, 0, 2'b00, "strb_full");
        wbuf[0] = 32'hAABB_CCDD;
        do_write(32'h200, 0, 2'b01, 4'd4, 4'b0101, -1, 0, 2'b00, "strb_0101");
        edat[0] = 32'h11BB_33DD; eres[0] = 2'b00;
        do_read(32'h200, 0, 2'b01, 4'd4, 0, "rd_strb");

        // rready stalls during an 8-beat read
        for (int i = 0; i < 8; i++) begin edat[i] = pat(32'(4 * i)); eres[i] = 2'b00; end
        do_read(32'h0, 7, 2'b01, 4'd9, 1, "rd_stall");

        // early wlast: data still lands, response flags SLVERR
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'h300 + 32'(i); edat[i] = 32'h300 + 32'(i); eres[i] = 2'b00;
        end
        do_write(32'h300, 3, 2'b01, 4'd6, 4'hF, 1, 0, 2'b10, "wr_early_wlast");
        do_read(32'h300, 3, 2'b01, 4'd6, 0, "rd_early_wlast");

        // top-of-array boundary
        wbuf[0] = 32'h1234_5678;
        do_write(32'h3FFC, 0, 2'b01, 4'd8, 4'hF, -1, 0, 2'b00, "wr_top");
        edat[0] = 32'h1234_5678; eres[0] = 2'b00;
        edat[1] = 32'h0;         eres[1] = 2'b11;
        do_read(32'h3FFC, 1, 2'b01, 4'd8, 0, "rd_boundary");

        // out-of-range write must not alias onto word 0
        wbuf[0] = 32'hDEAD_BEEF;
        do_write(32'h4000, 0, 2'b01, 4'd10, 4'hF, -1, 0, 2'b11, "wr_decerr");
        wbuf[0] = 32'h55; wbuf[1] = 32'h66;
        do_write(32'h3FFC, 1, 2'b01, 4'd11, 4'hF, -1, 0, 2'b11, "wr_cross_top");
        edat[0] = 32'hC0DE_0000; eres[0] = 2'b00;
        do_read(32'h0, 0, 2'b01, 4'd12, 0, "rd_no_alias");
        edat[0] = 32'h55;
        do_read(32'h3FFC, 0, 2'b01, 4'd12, 0, "rd_cross_top");

        // reset in the middle of a write burst
        aw_send(32'h500, 8'd7, 2'b01, 4'd7, ok);
        w_send(32'hA0, 4'hF, 1'b0, ok);
        w_send(32'hA1, 4'hF, 1'b0, ok);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_burst_reset awready/wready/bvalid", {29'd0, awready, wready, bvalid},
            {29'd0, 3'b100});
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
